// File: rtl/result_stream_tx_pkg.sv
// Shared constants and state encoding for the result stream transmitter.
package result_stream_tx_pkg;

  localparam int DEF_DMA_WIDTH   = 64;
  localparam int DEF_SAMPLE_W    = 14;
  localparam int DEF_FRAME_WORDS = 256;
  localparam int DEF_FIFO_DEPTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DRAIN
  } tx_state_t;

endpackage

// File: rtl/result_stream_tx_fifo.sv
// First-word-fall-through FIFO carrying {last, data} beats toward the stream port.
module axis_tx_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && (r_count < FULL_CNT);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head entry is gated so stale memory never shows on an empty FIFO.
  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rd] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/result_stream_tx.sv
// Packs sample pairs from the compute block into fixed-length 64-bit stream frames.
module result_stream_tx
  import result_stream_tx_pkg::*;
#(
  parameter int DMA_WIDTH   = DEF_DMA_WIDTH,
  parameter int SAMPLE_W    = DEF_SAMPLE_W,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic                 i_start,
  input  logic                 i_sample_valid,
  input  logic [SAMPLE_W-1:0]  i_ch1,
  input  logic [SAMPLE_W-1:0]  i_ch2,
  output logic [DMA_WIDTH-1:0] o_m_axis_tdata,
  output logic [7:0]           o_m_axis_tkeep,
  output logic                 o_m_axis_tlast,
  output logic                 o_m_axis_tvalid,
  input  logic                 i_m_axis_tready,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_overflow
);

  localparam int PAD   = 16 - SAMPLE_W;
  localparam int CW    = $clog2(FRAME_WORDS + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]    LAST_IDX  = CW'(FRAME_WORDS - 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_M1  = CNT_W'(FIFO_DEPTH - 1);

  tx_state_t           r_state;
  logic                r_half_pend;
  logic [CW-1:0]       r_word_cnt;
  logic [31:0]         r_low;
  logic                r_overflow;
  logic                r_busy;
  logic                r_done;

  logic [31:0]         w_pair;
  logic                w_take;
  logic                w_word_push;
  logic                w_is_last;
  logic                w_accept;
  logic                w_pop;
  logic [DMA_WIDTH:0]  w_fifo_out;
  logic                w_fifo_valid;
  logic [CNT_W-1:0]    w_fifo_count;

  assign w_pair      = {{{PAD{i_ch2[SAMPLE_W-1]}}, i_ch2}, {{PAD{i_ch1[SAMPLE_W-1]}}, i_ch1}};
  assign w_take      = (r_state == ST_CAPTURE) && i_sample_valid && i_en;
  assign w_word_push = w_take && r_half_pend;
  assign w_is_last   = (r_word_cnt == LAST_IDX);
  assign w_pop       = w_fifo_valid && i_m_axis_tready;

  // One slot is held back for the closing word so tlast is never lost.
  assign w_accept = w_word_push &&
                    (w_is_last ? (w_fifo_count < DEPTH_C) : (w_fifo_count < DEPTH_M1));

  axis_tx_fifo #(
    .WIDTH (DMA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_accept),
    .i_data  ({w_is_last, w_pair, r_low}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_out),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_half_pend <= 1'b0;
      r_word_cnt  <= '0;
      r_low       <= '0;
      r_overflow  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_pop && w_fifo_out[DMA_WIDTH];
      case (r_state)
        ST_IDLE: begin
          if (i_start && i_en) begin
            r_state     <= ST_CAPTURE;
            r_word_cnt  <= '0;
            r_half_pend <= 1'b0;
            r_overflow  <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (w_take) begin
            if (!r_half_pend) begin
              r_low       <= w_pair;
              r_half_pend <= 1'b1;
            end else begin
              r_half_pend <= 1'b0;
              r_word_cnt  <= r_word_cnt + 1'b1;
              if (!w_accept) r_overflow <= 1'b1;
              if (w_is_last) r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!w_fifo_valid) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_m_axis_tdata  = w_fifo_out[DMA_WIDTH-1:0];
  assign o_m_axis_tlast  = w_fifo_out[DMA_WIDTH];
  assign o_m_axis_tvalid = w_fifo_valid;
  assign o_m_axis_tkeep  = w_fifo_valid ? 8'hFF : 8'h00;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_overflow      = r_overflow;

endmodule

// File: tb/tb_result_stream_tx.sv
// Directed bench: dutA runs 4-word frames, dutB runs 8-word frames, both with a 4-deep FIFO.
module tb_result_stream_tx;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        en = 1'b1;
  logic        start = 1'b0;
  logic        sampleValid = 1'b0;
  logic [13:0] ch1 = '0;
  logic [13:0] ch2 = '0;
  logic        tready = 1'b0;

  logic [63:0] tdataA, tdataB;
  logic [7:0]  tkeepA, tkeepB;
  logic        tlastA, tlastB, tvalidA, tvalidB;
  logic        busyA, busyB, doneA, doneB, ovfA, ovfB;

  int nCompared = 0;
  int nMismatched = 0;

  logic [63:0] beatDataA[$];
  logic        beatLastA[$];
  logic [63:0] beatDataB[$];
  logic        beatLastB[$];
  int          doneCntA = 0;
  int          doneCntB = 0;

  always #5 clk = ~clk;

  result_stream_tx #(.DMA_WIDTH(64), .SAMPLE_W(14), .FRAME_WORDS(4), .FIFO_DEPTH(4)) dutA (
    .i_clk(clk), .i_rst_n(rstN), .i_en(en), .i_start(start), .i_sample_valid(sampleValid),
    .i_ch1(ch1), .i_ch2(ch2), .o_m_axis_tdata(tdataA), .o_m_axis_tkeep(tkeepA),
    .o_m_axis_tlast(tlastA), .o_m_axis_tvalid(tvalidA), .i_m_axis_tready(tready),
    .o_busy(busyA), .o_done(doneA), .o_overflow(ovfA)
  );

  result_stream_tx #(.DMA_WIDTH(64), .SAMPLE_W(14), .FRAME_WORDS(8), .FIFO_DEPTH(4)) dutB (
    .i_clk(clk), .i_rst_n(rstN), .i_en(en), .i_start(start), .i_sample_valid(sampleValid),
    .i_ch1(ch1), .i_ch2(ch2), .o_m_axis_tdata(tdataB), .o_m_axis_tkeep(tkeepB),
    .o_m_axis_tlast(tlastB), .o_m_axis_tvalid(tvalidB), .i_m_axis_tready(tready),
    .o_busy(busyB), .o_done(doneB), .o_overflow(ovfB)
  );

  // Inputs change 2ns after the rising edge, so values seen here hold until the next edge.
  always @(negedge clk) begin
    if (tvalidA && tready) begin
      beatDataA.push_back(tdataA);
      beatLastA.push_back(tlastA);
    end
    if (tvalidB && tready) begin
      beatDataB.push_back(tdataB);
      beatLastB.push_back(tlastB);
    end
    if (doneA) doneCntA++;
    if (doneB) doneCntB++;
  end

  // Expected word from samples k=lo and k=hi with ch1=k, ch2=-k.
  function automatic logic [63:0] expWord(input int lo, input int hi);
    return {16'(-hi), 16'(hi), 16'(-lo), 16'(lo)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clearMon();
    beatDataA.delete();
    beatLastA.delete();
    beatDataB.delete();
    beatLastB.delete();
    doneCntA = 0;
    doneCntB = 0;
  endtask

  task automatic applyReset();
    rstN = 1'b0;
    start = 1'b0;
    sampleValid = 1'b0;
    en = 1'b1;
    tick();
    clearMon();
    rstN = 1'b1;
    tick();
  endtask

  task automatic startFrame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic sendSample(input int k);
    sampleValid = 1'b1;
    ch1 = 14'(k);
    ch2 = 14'(-k);
    tick();
    sampleValid = 1'b0;
  endtask

  task automatic waitBeatsA(input int n, input int budget);
    int c = 0;
    while (beatDataA.size() < n && c < budget) begin
      tick();
      c++;
    end
  endtask

  task automatic waitBeatsB(input int n, input int budget);
    int c = 0;
    while (beatDataB.size() < n && c < budget) begin
      tick();
      c++;
    end
  endtask

  // Checks a full 4-beat frame of samples 1..8 on dutA.
  task automatic checkFrameA(input string tag);
    nCompared++;
    if (beatDataA.size() !== 4) begin
      nMismatched++;
      $display("[TB] FAIL %s beat_count got %0d want 4", tag, beatDataA.size());
    end
    for (int w = 0; w < 4; w++) begin
      if (w < beatDataA.size()) begin
        nCompared++;
        if (beatDataA[w] !== expWord(2*w+1, 2*w+2)) begin
          nMismatched++;
          $display("[TB] FAIL %s word%0d got %h want %h", tag, w, beatDataA[w], expWord(2*w+1, 2*w+2));
        end
        nCompared++;
        if (beatLastA[w] !== (w == 3)) begin
          nMismatched++;
          $display("[TB] FAIL %s tlast%0d got %b want %b", tag, w, beatLastA[w], (w == 3));
        end
      end
    end
    nCompared++;
    if (doneCntA !== 1) begin
      nMismatched++;
      $display("[TB] FAIL %s done_count got %0d want 1", tag, doneCntA);
    end
    nCompared++;
    if (ovfA !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL %s overflow got %b want 0", tag, ovfA);
    end
    nCompared++;
    if (busyA !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL %s busy_after got %b want 0", tag, busyA);
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    #3;
    nCompared++;
    if ({tdataA, tkeepA, tlastA, tvalidA, busyA, doneA, ovfA} !== 77'd0) begin
      nMismatched++;
      $display("[TB] FAIL reset_outputs got %h/%h/%b%b%b%b%b want all zero",
               tdataA, tkeepA, tlastA, tvalidA, busyA, doneA, ovfA);
    end
    nCompared++;
    if ({tvalidB, busyB, ovfB} !== 3'b000) begin
      nMismatched++;
      $display("[TB] FAIL reset_outputsB got %b%b%b want 000", tvalidB, busyB, ovfB);
    end
  endtask

  task automatic test_basic();
    applyReset();
    tready = 1'b1;
    startFrame();
    nCompared++;
    if (busyA !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL basic_busy got %b want 1", busyA);
    end
    for (int k = 1; k <= 8; k++) sendSample(k);
    waitBeatsA(4, 40);
    ticks(4);
    checkFrameA("basic");
  endtask

  task automatic test_backpressure();
    applyReset();
    tready = 1'b0;
    startFrame();
    for (int k = 1; k <= 8; k++) sendSample(k);
    for (int i = 0; i < 20; i++) begin
      tick();
      nCompared++;
      if (tvalidA !== 1'b1 || tdataA !== expWord(1, 2) || tlastA !== 1'b0 || tkeepA !== 8'hFF) begin
        nMismatched++;
        $display("[TB] FAIL stall_hold cyc%0d got v=%b d=%h l=%b k=%h want v=1 d=%h l=0 k=ff",
                 i, tvalidA, tdataA, tlastA, tkeepA, expWord(1, 2));
      end
    end
    tready = 1'b1;
    waitBeatsA(4, 40);
    ticks(4);
    checkFrameA("backpressure");
  endtask

  task automatic test_overflow();
    logic [63:0] wantData [4];
    logic        wantLast [4];
    wantData = '{expWord(1, 2), expWord(3, 4), expWord(5, 6), expWord(15, 16)};
    wantLast = '{1'b0, 1'b0, 1'b0, 1'b1};
    applyReset();
    tready = 1'b0;
    startFrame();
    for (int k = 1; k <= 16; k++) sendSample(k);
    tick();
    nCompared++;
    if (ovfB !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL ovf_set got %b want 1", ovfB);
    end
    tready = 1'b1;
    waitBeatsB(4, 40);
    ticks(4);
    nCompared++;
    if (beatDataB.size() !== 4) begin
      nMismatched++;
      $display("[TB] FAIL ovf_beat_count got %0d want 4", beatDataB.size());
    end
    for (int w = 0; w < 4; w++) begin
      if (w < beatDataB.size()) begin
        nCompared++;
        if (beatDataB[w] !== wantData[w] || beatLastB[w] !== wantLast[w]) begin
          nMismatched++;
          $display("[TB] FAIL ovf_beat%0d got %h/%b want %h/%b",
                   w, beatDataB[w], beatLastB[w], wantData[w], wantLast[w]);
        end
      end
    end
    nCompared++;
    if (ovfB !== 1'b1 || doneCntB !== 1 || busyB !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL ovf_after got ovf=%b done=%0d busy=%b want 1/1/0", ovfB, doneCntB, busyB);
    end
    startFrame();
    nCompared++;
    if (ovfB !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL ovf_clear got %b want 0", ovfB);
    end
  endtask

  task automatic test_odd_count();
    applyReset();
    tready = 1'b1;
    startFrame();
    for (int k = 1; k <= 7; k++) sendSample(k);
    waitBeatsA(3, 40);
    ticks(6);
    nCompared++;
    if (beatDataA.size() !== 3 || busyA !== 1'b1 || doneCntA !== 0) begin
      nMismatched++;
      $display("[TB] FAIL odd_partial got beats=%0d busy=%b done=%0d want 3/1/0",
               beatDataA.size(), busyA, doneCntA);
    end
    for (int w = 0; w < 3; w++) begin
      if (w < beatDataA.size()) begin
        nCompared++;
        if (beatLastA[w] !== 1'b0 || beatDataA[w] !== expWord(2*w+1, 2*w+2)) begin
          nMismatched++;
          $display("[TB] FAIL odd_beat%0d got %h/%b want %h/0",
                   w, beatDataA[w], beatLastA[w], expWord(2*w+1, 2*w+2));
        end
      end
    end
    sendSample(8);
    waitBeatsA(4, 40);
    ticks(4);
    checkFrameA("odd_complete");
  endtask

  task automatic test_reset_mid();
    applyReset();
    tready = 1'b0;
    startFrame();
    for (int k = 1; k <= 3; k++) sendSample(k);
    tick();
    nCompared++;
    if (tvalidA !== 1'b1 || busyA !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL mid_pre got v=%b busy=%b want 1/1", tvalidA, busyA);
    end
    #1 rstN = 1'b0;
    #1;
    nCompared++;
    if ({tdataA, tkeepA, tlastA, tvalidA, busyA, doneA, ovfA} !== 77'd0) begin
      nMismatched++;
      $display("[TB] FAIL mid_reset_outputs got %h/%h/%b%b%b%b%b want all zero",
               tdataA, tkeepA, tlastA, tvalidA, busyA, doneA, ovfA);
    end
    tick();
    clearMon();
    rstN = 1'b1;
    tick();
    tready = 1'b1;
    startFrame();
    for (int k = 1; k <= 8; k++) sendSample(k);
    waitBeatsA(4, 40);
    ticks(4);
    checkFrameA("after_reset");
  endtask

  task automatic test_en_gating();
    applyReset();
    tready = 1'b1;
    startFrame();
    sendSample(1);
    sendSample(2);
    en = 1'b0;
    sendSample(100);
    start = 1'b1;
    sendSample(101);
    start = 1'b0;
    sendSample(102);
    sendSample(103);
    tick();
    nCompared++;
    if (busyA !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL en_hold_busy got %b want 1", busyA);
    end
    en = 1'b1;
    for (int k = 3; k <= 8; k++) sendSample(k);
    waitBeatsA(4, 40);
    ticks(4);
    checkFrameA("en_gating");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_odd_count();
    test_reset_mid();
    test_en_gating();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/result_stream_tx.md
Name: result_stream_tx

Overview:
- Transmit-side counterpart of the DMA parameter loader. It captures compute-block output samples (dac_ch1/dac_ch2 on each comp_ready pulse) and packs them into 64-bit AXI-Stream words.
- Each frame is fixed-length and ends with tlast. Words are buffered in a small FIFO and drive the m_axis port toward the DMA S2MM channel.
- Sits in the design_clk domain beside the control unit. A frame starts on a start pulse from the control unit or host.

Parameters:
- DMA_WIDTH, 64 (`DMA_WIDTH): stream data width. Only 64 is supported.
- SAMPLE_W, 14: width of each input sample channel.
- FRAME_WORDS, 256: number of 64-bit words per frame. Must be ≥1.
- FIFO_DEPTH, 16: output FIFO entries. Must be a power of 2 and ≥4.

Ports:
- clk  in  1  design clock
- rst  in  1  asynchronous active-low reset
- en  in  1  global enable. When low, sample_valid and start are ignored; the output side keeps draining.
- start  in  1  one-cycle pulse; arms a capture frame
- sample_valid  in  1  one-cycle pulse per computed sample (comp_ready)
- ch1  in  SAMPLE_W  signed sample, channel 1
- ch2  in  SAMPLE_W  signed sample, channel 2
- m_axis_tdata  out  64  packed data
- m_axis_tkeep  out  8  always 8'hFF while tvalid is high
- m_axis_tlast  out  1  high on the final word of a frame
- m_axis_tvalid  out  1  FIFO not empty
- m_axis_tready  in  1  downstream ready
- busy  out  1  high in CAPTURE or DRAIN
- done  out  1  one-cycle pulse when the last word of a frame is accepted downstream
- overflow  out  1  sticky; set when a word is dropped, cleared on accepted start

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; half_pend=0; word_cnt=0; FIFO emptied.
  - All outputs 0: tdata=0, tkeep=0, tlast=0, tvalid=0, busy=0, done=0, overflow=0.
  - Reset mid-frame discards all buffered data. No tlast is emitted for the aborted frame.
- Sample pair: pair = {sext16(ch2), sext16(ch1)} (32 bits).
- Word packing: the first pair of a word goes to bits [31:0], the second to [63:32].
- States:
  - IDLE: on start&en, go to CAPTURE; clear word_cnt, half_pend and overflow. sample_valid is ignored.
  - CAPTURE, on sample_valid&en:
    - If half_pend=0: store pair in low_reg and set half_pend=1.
    - Else: push {pair, low_reg} with last=(word_cnt==FRAME_WORDS-1), clear half_pend, increment word_cnt.
    - After the last word is pushed, go to DRAIN.
  - DRAIN: when the FIFO is empty and no beat is pending, go to IDLE.
- start outside IDLE is ignored.
- Push rules, using the FIFO count sampled before the cycle:
  - A non-last word is accepted only if count < FIFO_DEPTH-1. Otherwise it is dropped, overflow is set, and word_cnt still increments.
  - The last word is accepted if count < FIFO_DEPTH. This is always true, because one slot stays reserved. tlast is therefore always delivered.
- Simultaneous push and pop: the count changes by net 0. The acceptance decision still uses the pre-cycle count.
- Latency: a word pushed in cycle N appears with tvalid=1 in cycle N+1 (FWFT registered output).
- Output handshake:
  - A beat transfers when tvalid&tready.
  - tdata, tlast and tkeep must hold stable while tvalid=1 and tready=0.
  - tvalid must never drop without a transfer, except on reset.
- done: asserted the cycle after the tlast beat transfers.
- en low during CAPTURE: the capture freezes (no sample intake) and the state is retained. Output draining continues.

Decomposition:
- Shared constants come from def.vh: `DMA_WIDTH. Add `TX_FRAME_WORDS and `TX_FIFO_DEPTH there as the default sources.
- One sub-module: axis_tx_fifo. It is a synchronous FWFT FIFO, 65 bits wide ({last, data}), with a count output, the same clk, and async active-low rst.
- FSM, packing and push-rule logic live in result_stream_tx.

Test Plan (FRAME_WORDS=4, FIFO_DEPTH=4 unless noted):
- Basic frame: start, then 8 sample_valid pulses with ch1=k, ch2=-k for k=1..8, tready=1. Expect:
  - 4 beats, word0 = 0xFFFE0002_FFFF0001.
  - tlast only on beat 3; done pulses once; overflow=0; busy low afterward.
- Backpressure: same stimulus with tready=0 for 20 cycles, then 1. Expect:
  - tdata and tlast stable while stalled.
  - No loss; identical beat sequence.
- Overflow: FRAME_WORDS=8, tready=0, 16 samples, then release. Expect:
  - Words 0-2 accepted, words 3-6 dropped, word 7 accepted with tlast.
  - 4 beats out; overflow=1 until the next start.
- Odd sample count: 7 samples, then none. Expect 3 beats, no tlast, busy stays high. A further sample completes word 3 with tlast.
- Reset mid-frame: rst low after 3 samples and 1 pushed word. Expect:
  - All outputs 0 immediately.
  - A new start plus 8 samples yields a clean 4-beat frame.
- en gating: en=0 during 4 sample pulses and one start pulse mid-frame. Expect those samples ignored, no restart, and frame contents contain only samples taken with en=1.
